alu_cmd_sequencer: RTL

//  Upstream front-end for the 16-bit ALU. Accepts operand/opcode commands on a valid/ready port and buffers them in a small FIFO.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_cmd_fifo.sv | 58 +++++
 rtl/alu_cmd_sequencer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command front-end: default width, opcode
// encoding, sequencer state encoding and a latency-counter sizing helper.
package alu_pkg;

  localparam int ALU_WIDTH = 16;
  localparam int ALU_DEPTH = 4;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // A zero-latency ALU still needs a 1-bit counter so the port never collapses.
  function automatic int lat_cnt_width(input int lat);
    return (lat > 0) ? $clog2(lat + 1) : 1;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: power-of-two depth, wrapping pointers, full/empty derived from
// the occupancy counter. Storage is not reset; only pointers and count are.
module alu_cmd_fifo #(
  parameter int W     = 35,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Front-end for the 16-bit ALU: queues commands, issues one at a time on
// registered operand lines, waits the ALU latency and holds the response.
//
//  state | meaning
//  IDLE  | nothing in flight, waiting for the FIFO to become non-empty
//  EXEC  | alu_* driven and stable, counting down the ALU latency
//  RESP  | rsp_* captured and held until rsp_ready
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int DEPTH   = ALU_DEPTH,
  parameter int ALU_LAT = 1,
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [2:0]       cmd_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_err,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [2:0]       rsp_sel,
  output logic             busy,
  output logic [CW-1:0]    cmd_count
);

  localparam int FW = 2 * WIDTH + 3;
  localparam int LW = lat_cnt_width(ALU_LAT);

  state_t           state;
  logic [LW-1:0]    cnt;
  logic [FW-1:0]    fifo_wdata;
  logic [FW-1:0]    fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [2:0]       q_sel;
  logic [WIDTH-1:0] q_a;
  logic [WIDTH-1:0] q_b;

  assign fifo_wdata        = {cmd_sel, cmd_a, cmd_b};
  assign {q_sel, q_a, q_b} = fifo_rdata;

  // Holding ready low through reset keeps commands from landing in a FIFO being cleared.
  assign cmd_ready = reset & ~fifo_full;
  assign push      = cmd_valid & cmd_ready;
  assign busy      = (state != ST_IDLE) | ~fifo_empty;

  always_comb begin
    pop = 1'b0;
    if (!fifo_empty) begin
      pop = (state == ST_IDLE) || ((state == ST_RESP) && rsp_ready);
    end
  end

  alu_cmd_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (cmd_count)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= 3'b000;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      rsp_sel   <= 3'b000;
    end else begin
      if (pop) begin
        alu_a   <= q_a;
        alu_b   <= q_b;
        alu_sel <= q_sel;
        cnt     <= LW'(ALU_LAT);
      end
      case (state)
        ST_IDLE: begin
          if (pop) begin
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - LW'(1);
          end else begin
            rsp_data  <= alu_out;
            rsp_err   <= alu_err;
            rsp_sel   <= alu_sel;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          // Chaining straight into EXEC avoids an IDLE bubble between responses.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= pop ? ST_EXEC : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
